// File: rtl/mac_pkg.sv
// Shared constants and the sequencer state type for the 4-lane mac datapath.
package mac_pkg;
  localparam int DATA_W = 16;
  localparam int LANES  = 4;
  localparam int PROD_W = 32;
  localparam int RES_W  = 34;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } mac_seq_state_t;
endpackage

// File: rtl/mac_tag_pipe.sv
// Valid-bit delay line of DEPTH stages; marks cycles where a pipelined result is live.
module mac_tag_pipe #(
  parameter int DEPTH = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];
endmodule

// File: rtl/mac_seq.sv
// Dot-product sequencer: streams len quads from two buffers into mac and
// accumulates the tagged partial sums into one total behind a valid/ready port.
module mac_seq
  import mac_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int MAC_LAT = 4,
  parameter int ACC_W   = 34 + ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W:0]           len,
  input  logic [ADDR_W-1:0]         ifm_base,
  input  logic [ADDR_W-1:0]         w_base,
  output logic                      busy,
  output logic                      rd_en,
  output logic [ADDR_W-1:0]         ifm_addr,
  output logic [ADDR_W-1:0]         w_addr,
  input  logic [DATA_W*LANES-1:0]   ifm_rdata,
  input  logic [DATA_W*LANES-1:0]   w_rdata,
  output logic [DATA_W*LANES-1:0]   mac_ifm,
  output logic [DATA_W*LANES-1:0]   mac_w,
  input  logic [RES_W-1:0]          mac_result,
  output logic [ACC_W-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready
);
  localparam int CNT_W = ADDR_W + 1;

  // Output handshake: out_data is held while out_valid is high and the
  // transfer completes on the edge where out_valid && out_ready.
  mac_seq_state_t    state;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  res_cnt;
  logic [ADDR_W-1:0] ifm_base_q;
  logic [ADDR_W-1:0] w_base_q;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_next;
  logic              tag;
  logic              last_res;

  mac_tag_pipe #(.DEPTH(1 + MAC_LAT)) u_tag_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  (rd_en),
    .dout (tag)
  );

  assign mac_ifm  = ifm_rdata;
  assign mac_w    = w_rdata;
  assign busy     = (state != S_IDLE);
  assign acc_next = acc + ACC_W'(mac_result);
  assign last_res = tag && ((res_cnt + CNT_W'(1)) == len_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      len_q      <= '0;
      issue_cnt  <= '0;
      res_cnt    <= '0;
      ifm_base_q <= '0;
      w_base_q   <= '0;
      acc        <= '0;
      rd_en      <= 1'b0;
      ifm_addr   <= '0;
      w_addr     <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
    end else begin
      // Partial sums can land while reads are still being issued.
      if (tag) begin
        acc     <= acc_next;
        res_cnt <= res_cnt + CNT_W'(1);
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q      <= len;
            ifm_base_q <= ifm_base;
            w_base_q   <= w_base;
            acc        <= '0;
            res_cnt    <= '0;
            if (len == '0) begin
              issue_cnt <= '0;
              out_data  <= '0;
              out_valid <= 1'b1;
              state     <= S_HOLD;
            end else begin
              issue_cnt <= CNT_W'(1);
              ifm_addr  <= ifm_base;
              w_addr    <= w_base;
              rd_en     <= 1'b1;
              state     <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (issue_cnt == len_q) begin
            rd_en <= 1'b0;
            state <= S_DRAIN;
          end else begin
            ifm_addr  <= ifm_base_q + issue_cnt[ADDR_W-1:0];
            w_addr    <= w_base_q + issue_cnt[ADDR_W-1:0];
            issue_cnt <= issue_cnt + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          if (last_res) begin
            out_data  <= acc_next;
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq: BRAM and mac stand-ins, address scoreboard, and a
// reference dot product computed directly from the buffer contents.
module tb_mac_seq;
  localparam int ADDR_W  = 10;
  localparam int MAC_LAT = 4;
  localparam int ACC_W   = 34 + ADDR_W;
  localparam int N       = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] ifm_base;
  logic [ADDR_W-1:0] w_base;
  logic              busy;
  logic              rd_en;
  logic [ADDR_W-1:0] ifm_addr;
  logic [ADDR_W-1:0] w_addr;
  logic [63:0]       ifm_rdata;
  logic [63:0]       w_rdata;
  logic [63:0]       mac_ifm;
  logic [63:0]       mac_w;
  logic [33:0]       mac_result;
  logic [ACC_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;

  mac_seq #(.ADDR_W(ADDR_W), .MAC_LAT(MAC_LAT), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .ifm_base   (ifm_base),
    .w_base     (w_base),
    .busy       (busy),
    .rd_en      (rd_en),
    .ifm_addr   (ifm_addr),
    .w_addr     (w_addr),
    .ifm_rdata  (ifm_rdata),
    .w_rdata    (w_rdata),
    .mac_ifm    (mac_ifm),
    .mac_w      (mac_w),
    .mac_result (mac_result),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  // ---------------- buffer and mac stand-ins ----------------
  logic [63:0] ifm_mem[N];
  logic [63:0] w_mem[N];
  logic [33:0] mac_pipe[MAC_LAT];

  function automatic logic [33:0] dot4(input logic [63:0] a, input logic [63:0] b);
    logic [33:0] s;
    s = '0;
    for (int k = 0; k < 4; k++) s = s + 34'(a[16*k +: 16]) * 34'(b[16*k +: 16]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (rd_en) begin
      ifm_rdata <= ifm_mem[ifm_addr];
      w_rdata   <= w_mem[w_addr];
    end
  end

  always @(posedge clk) begin
    for (int i = MAC_LAT - 1; i > 0; i--) mac_pipe[i] <= mac_pipe[i-1];
    mac_pipe[0] <= dot4(mac_ifm, mac_w);
  end
  assign mac_result = mac_pipe[MAC_LAT-1];

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [2*ADDR_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_sum(input int l, input int ib, input int wb);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < l; i++) s += 64'(dot4(ifm_mem[(ib + i) % N], w_mem[(wb + i) % N]));
    return s;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      ifm_mem[i] = {$urandom, $urandom};
      w_mem[i]   = {$urandom, $urandom};
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_rd_en"}, 64'(rd_en), 0);
    check({tag, "_ifm_addr"}, 64'(ifm_addr), 0);
    check({tag, "_w_addr"}, 64'(w_addr), 0);
    check({tag, "_out_valid"}, 64'(out_valid), 0);
    check({tag, "_out_data"}, 64'(out_data), 0);
  endtask

  // ---------------- driver ----------------
  // noisy keeps start high from cycle 0 through the handshake cycle.
  task automatic run_job(input int l, input int ib, input int wb, input int ready_wait,
                         input bit noisy, input string tag);
    int          cyc;
    int          exp_cyc;
    bit          seen;
    bit          busy_ok;
    bit          stable;
    logic [63:0] exp_sum;
    logic [ACC_W-1:0]    held;
    logic [2*ADDR_W-1:0] a;
    exp_q.delete();
    for (int i = 0; i < l; i++)
      exp_q.push_back({ADDR_W'((ib + i) % N), ADDR_W'((wb + i) % N)});
    exp_sum = model_sum(l, ib, wb);
    exp_cyc = (l == 0) ? 1 : l + MAC_LAT + 2;

    @(negedge clk);
    start     = 1'b1;
    len       = (ADDR_W + 1)'(l);
    ifm_base  = ADDR_W'(ib);
    w_base    = ADDR_W'(wb);
    out_ready = 1'b0;
    cyc = 0; seen = 0; busy_ok = 1;
    while (!seen && cyc < l + MAC_LAT + 50) begin
      @(negedge clk);
      cyc++;
      if (!noisy) start = 1'b0;
      if (!busy) busy_ok = 0;
      if (rd_en) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra_read"}, 64'({ifm_addr, w_addr}), 64'hFFFF_FFFF);
        end else begin
          a = exp_q.pop_front();
          check({tag, "_addr"}, 64'({ifm_addr, w_addr}), 64'(a));
        end
      end
      if (out_valid) seen = 1;
    end
    check({tag, "_valid_seen"}, 64'(seen), 1);
    check({tag, "_valid_cycle"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_data"}, 64'(out_data), exp_sum);
    check({tag, "_reads_left"}, 64'(exp_q.size()), 0);
    check({tag, "_busy_during"}, 64'(busy_ok), 1);

    held = out_data;
    stable = 1;
    repeat (ready_wait) begin
      @(negedge clk);
      if (!out_valid || out_data !== held || !busy) stable = 0;
    end
    check({tag, "_hold_stable"}, 64'(stable), 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_after_hs"}, 64'(out_valid), 0);
    check({tag, "_busy_after_hs"}, 64'(busy), 0);
    start = 1'b0;
    @(negedge clk);
    check({tag, "_idle_after"}, 64'({busy, rd_en}), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; len = '0; ifm_base = '0; w_base = '0; out_ready = 1'b0;
    ifm_rdata = '0; w_rdata = '0;
    for (int i = 0; i < MAC_LAT; i++) mac_pipe[i] = '0;
    fill_random();
    repeat (3) @(negedge clk);
    check_reset_values("in_reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_values("idle");

    // Single quad: 1*5+2*6+3*7+4*8 = 70, held for 3 cycles.
    ifm_mem[5] = {16'd4, 16'd3, 16'd2, 16'd1};
    w_mem[9]   = {16'd8, 16'd7, 16'd6, 16'd5};
    check("single_model", model_sum(1, 5, 9), 70);
    run_job(1, 5, 9, 3, 0, "single");

    // Address wrap on the ifm side.
    ifm_mem[N-2] = 64'h0001_0001_0001_0001;
    ifm_mem[N-1] = 64'h0001_0001_0001_0001;
    ifm_mem[0]   = 64'h0001_0001_0001_0001;
    ifm_mem[1]   = 64'h0001_0001_0001_0001;
    for (int i = 0; i < 4; i++) w_mem[i] = 64'h0001_0001_0001_0001;
    run_job(4, N - 2, 0, 0, 0, "wrap");

    // Zero-length job, with start held high throughout.
    run_job(0, 17, 33, 2, 1, "len0");

    // Full-length job at maximum lane values.
    for (int i = 0; i < N; i++) begin
      ifm_mem[i] = 64'hFFFF_FFFF_FFFF_FFFF;
      w_mem[i]   = 64'hFFFF_FFFF_FFFF_FFFF;
    end
    check("max_model", model_sum(N, 0, 0), 64'd4 * 64'd1024 * 64'hFFFE_0001);
    run_job(N, 0, 0, 1, 0, "max_len");

    // Randomized jobs, some with start noise during the job.
    fill_random();
    for (int j = 0; j < 8; j++) begin
      run_job($urandom_range(0, 3) == 0 ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 40)),
              $urandom_range(0, N - 1), $urandom_range(0, N - 1),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rand");
    end

    // Reset in cycle 5 of a len=8 job, then a clean len=1 job.
    @(negedge clk);
    start = 1'b1; len = 11'd8; ifm_base = 10'd100; w_base = 10'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy_before", 64'(busy), 1);
    rst = 1'b1;
    #1;
    check_reset_values("abort_async");
    @(negedge clk);
    rst = 1'b0;
    run_job(1, 300, 400, 0, 0, "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
